// File: rtl/mc_issue_pkg.sv
// mc_issue_pkg: shared index type, hazard_cause bit positions and default multicycle mask
package mc_issue_pkg;
    typedef logic [5:0] reg_idx_t;
    typedef enum logic [1:0] {
        HC_RAW    = 2'd0,
        HC_WAW    = 2'd1,
        HC_STRUCT = 2'd2
    } hazard_cause_t;
    localparam logic [5:0] UNIT_MC_DEFAULT = 6'b000111;
endpackage

// File: rtl/mc_scoreboard.sv
// mc_scoreboard: in-flight destination busy bits, {is_fp, reg} indexed, with writeback bypass on lookup
module mc_scoreboard
    import mc_issue_pkg::*;
#(
    parameter int NUM_REGS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_en,
    input  reg_idx_t   set_idx,
    input  logic       wb_valid,
    input  reg_idx_t   wb_rd,
    input  reg_idx_t   rs1,
    input  reg_idx_t   rs2,
    input  reg_idx_t   rs3,
    input  reg_idx_t   rd,
    output logic [2:0] rs_busy,
    output logic       rd_busy
);
    logic [NUM_REGS-1:0] reg_busy;
    logic [NUM_REGS-1:0] eff_busy;
    always_comb begin
        eff_busy = reg_busy;
        if (wb_valid) eff_busy[wb_rd] = 1'b0;
    end
    assign rs_busy = {eff_busy[rs3], eff_busy[rs2], eff_busy[rs1]};
    assign rd_busy = eff_busy[rd];
    // x0 is hardwired, so it is never tracked; a same-cycle set overrides the writeback clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_busy <= '0;
        end else begin
            if (wb_valid) reg_busy[wb_rd] <= 1'b0;
            if (set_en && set_idx != '0) reg_busy[set_idx] <= 1'b1;
        end
    end
endmodule

// File: rtl/mc_issue_controller.sv
// mc_issue_controller: ID->EXE issue decision, unit occupancy, pipeline clears/enables and stall counter
module mc_issue_controller
    import mc_issue_pkg::*;
#(
    parameter int NUM_UNITS = 6,
    parameter logic [NUM_UNITS-1:0] UNIT_MC = NUM_UNITS'(UNIT_MC_DEFAULT),
    parameter int NUM_REGS = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [NUM_UNITS-1:0]   id_unit,
    input  reg_idx_t               id_rs1,
    input  reg_idx_t               id_rs2,
    input  reg_idx_t               id_rs3,
    input  logic [2:0]             id_rs_used,
    input  reg_idx_t               id_rd,
    input  logic                   id_wr_rd,
    input  logic                   wb_valid,
    input  reg_idx_t               wb_rd,
    input  logic [NUM_UNITS-1:0]   unit_done,
    input  logic [NUM_UNITS-1:0]   unit_stall,
    input  logic                   load_hazard,
    input  logic                   branch_hazard,
    input  logic                   stall_pipl,
    output logic                   issue_fire,
    output logic [2:0]             hazard_cause,
    output logic                   if_id_reg_clr,
    output logic                   id_exe_reg_clr,
    output logic                   exe_mem_reg_clr,
    output logic                   mem_wb_reg_clr,
    output logic                   pc_reg_en,
    output logic                   if_id_reg_en,
    output logic                   id_exe_reg_en,
    output logic                   exe_mem_reg_en,
    output logic                   mem_wb_reg_en,
    output logic [NUM_UNITS-1:0]   unit_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    logic [2:0] rs_busy;
    logic       rd_busy;
    logic       struct_haz;
    logic       hazard;
    logic       hold;

    mc_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (issue_fire & id_wr_rd),
        .set_idx (id_rd),
        .wb_valid(wb_valid),
        .wb_rd   (wb_rd),
        .rs1     (id_rs1),
        .rs2     (id_rs2),
        .rs3     (id_rs3),
        .rd      (id_rd),
        .rs_busy (rs_busy),
        .rd_busy (rd_busy)
    );

    // A multicycle unit finishing this cycle can accept the next op in the same cycle
    assign struct_haz = |(id_unit & ((UNIT_MC & unit_busy & ~unit_done) | (~UNIT_MC & unit_stall)));
    always_comb begin
        hazard_cause            = '0;
        hazard_cause[HC_RAW]    = id_valid & |(id_rs_used & rs_busy);
        hazard_cause[HC_WAW]    = id_valid & id_wr_rd & rd_busy;
        hazard_cause[HC_STRUCT] = id_valid & struct_haz;
    end
    assign hazard     = |hazard_cause;
    assign issue_fire = id_valid & ~hazard & ~load_hazard & ~branch_hazard & ~stall_pipl;
    assign hold       = stall_pipl | load_hazard | hazard;

    assign pc_reg_en       = ~hold;
    assign if_id_reg_en    = ~hold;
    assign id_exe_reg_en   = ~stall_pipl;
    assign exe_mem_reg_en  = ~stall_pipl;
    assign mem_wb_reg_en   = ~stall_pipl;
    assign if_id_reg_clr   = branch_hazard;
    assign id_exe_reg_clr  = branch_hazard | load_hazard | hazard;
    assign exe_mem_reg_clr = branch_hazard;
    assign mem_wb_reg_clr  = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unit_busy <= '0;
            stall_cnt <= '0;
        end else begin
            unit_busy <= (unit_busy & ~unit_done) | ({NUM_UNITS{issue_fire}} & id_unit & UNIT_MC);
            if (hazard && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mc_issue_controller.sv
// tb_mc_issue_controller: table-driven scenarios with a queue of expected output vectors
module tb_mc_issue_controller;
    import mc_issue_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid;
    logic [5:0] id_unit;
    reg_idx_t   id_rs1, id_rs2, id_rs3, id_rd, wb_rd;
    logic [2:0] id_rs_used;
    logic       id_wr_rd, wb_valid, load_hazard, branch_hazard, stall_pipl;
    logic [5:0] unit_done, unit_stall;
    logic       issue_fire;
    logic [2:0] hazard_cause;
    logic       if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr;
    logic       pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en;
    logic [5:0] unit_busy;
    logic [15:0] stall_cnt;

    mc_issue_controller #(.NUM_UNITS(6), .UNIT_MC(6'b000111), .NUM_REGS(64), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_unit(id_unit),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_wr_rd(id_wr_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .unit_done(unit_done), .unit_stall(unit_stall), .load_hazard(load_hazard),
        .branch_hazard(branch_hazard), .stall_pipl(stall_pipl), .issue_fire(issue_fire),
        .hazard_cause(hazard_cause), .if_id_reg_clr(if_id_reg_clr), .id_exe_reg_clr(id_exe_reg_clr),
        .exe_mem_reg_clr(exe_mem_reg_clr), .mem_wb_reg_clr(mem_wb_reg_clr), .pc_reg_en(pc_reg_en),
        .if_id_reg_en(if_id_reg_en), .id_exe_reg_en(id_exe_reg_en), .exe_mem_reg_en(exe_mem_reg_en),
        .mem_wb_reg_en(mem_wb_reg_en), .unit_busy(unit_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic v; logic [5:0] unit; logic [5:0] rs1, rs2, rs3; logic [2:0] used; logic [5:0] rd; logic wr;
        logic wbv; logic [5:0] wbrd; logic [5:0] done, ust; logic lh, bh, sp;
        logic fire; logic [2:0] hc; logic [5:0] ub;
    } row_t;
    typedef struct { string name; logic [34:0] v; } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] stalls = '0;
    logic [34:0] obs;

    assign obs = {issue_fire, hazard_cause, if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr,
                  pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en, unit_busy, stall_cnt};

    // argument order: valid unit rs1 rs2 rs3 used rd wr | wbv wbrd done ustall | lh bh sp | fire hc ub
    function automatic row_t mk(int v, int unit, int rs1, int rs2, int rs3, int used, int rd, int wr,
                                int wbv, int wbrd, int done, int ust, int lh, int bh, int sp,
                                int fire, int hc, int ub);
        row_t r;
        r.v = 1'(v); r.unit = 6'(unit); r.rs1 = 6'(rs1); r.rs2 = 6'(rs2); r.rs3 = 6'(rs3);
        r.used = 3'(used); r.rd = 6'(rd); r.wr = 1'(wr); r.wbv = 1'(wbv); r.wbrd = 6'(wbrd);
        r.done = 6'(done); r.ust = 6'(ust); r.lh = 1'(lh); r.bh = 1'(bh); r.sp = 1'(sp);
        r.fire = 1'(fire); r.hc = 3'(hc); r.ub = 6'(ub);
        return r;
    endfunction

    function automatic logic [34:0] exp_vec(row_t r, logic [15:0] sc);
        logic hold;
        hold = r.sp | r.lh | (r.v & |r.hc);
        return {r.fire, r.hc, r.bh, r.bh | r.lh | (r.v & |r.hc), r.bh, 1'b0,
                ~hold, ~hold, ~r.sp, ~r.sp, ~r.sp, r.ub, sc};
    endfunction

    task automatic drive(input row_t r);
        id_valid = r.v; id_unit = r.unit; id_rs1 = r.rs1; id_rs2 = r.rs2; id_rs3 = r.rs3;
        id_rs_used = r.used; id_rd = r.rd; id_wr_rd = r.wr; wb_valid = r.wbv; wb_rd = r.wbrd;
        unit_done = r.done; unit_stall = r.ust; load_hazard = r.lh; branch_hazard = r.bh; stall_pipl = r.sp;
    endtask

    task automatic push_exp(input string name, input row_t r);
        exp_t e;
        e.name = name;
        e.v = exp_vec(r, stalls);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        stalls = '0;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0));
        rows.push_back(mk(0,0,5,6,7,7,9,1, 0,0,0,0, 0,0,0, 0,0,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            push_exp($sformatf("reset[%0d]", i), rows[i]);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
            if (rows[i].v && rows[i].hc != 0 && stalls != 16'hFFFF) stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_raw_fdiv();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1,4,0,0,0,0,37,1, 0,0,0,0, 0,0,0, 1,0,0));
        rows.push_back(mk(1,0,37,0,0,1,38,1, 0,0,0,0, 0,0,0, 0,1,4));
        rows.push_back(mk(1,0,37,0,0,1,38,1, 0,0,0,0, 0,0,0, 0,1,4));
        rows.push_back(mk(1,0,37,0,0,1,38,1, 0,0,0,0, 0,0,0, 0,1,4));
        rows.push_back(mk(1,0,37,0,0,1,38,1, 1,37,4,0, 0,0,0, 1,0,4));
        rows.push_back(mk(0,0,0,0,0,0,0,0, 1,38,0,0, 0,0,0, 0,0,0));
        rows.push_back(mk(1,0,37,38,0,3,37,1, 0,0,0,0, 0,0,0, 1,0,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            push_exp($sformatf("raw_fdiv[%0d]", i), rows[i]);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
            if (rows[i].v && rows[i].hc != 0 && stalls != 16'hFFFF) stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1,2,0,0,0,0,0,0, 0,0,0,0, 0,0,0, 1,0,0));
        rows.push_back(mk(1,2,0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,4,2));
        rows.push_back(mk(1,2,0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,4,2));
        rows.push_back(mk(1,2,0,0,0,0,0,0, 0,0,2,0, 0,0,0, 1,0,2));
        rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,2));
        rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,2,0, 0,0,0, 0,0,2));
        rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0, 0,0,0, 0,0,0));
        rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0));
        rows.push_back(mk(1,8,0,0,0,0,0,0, 0,0,0,8, 0,0,0, 0,4,0));
        rows.push_back(mk(1,1,0,0,0,0,0,0, 0,0,0,1, 0,0,0, 1,0,0));
        rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,1));
        foreach (rows[i]) begin
            drive(rows[i]);
            push_exp($sformatf("back_to_back[%0d]", i), rows[i]);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
            if (rows[i].v && rows[i].hc != 0 && stalls != 16'hFFFF) stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_x0_f0();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1,0,0,0,0,0,0,1, 0,0,0,0, 0,0,0, 1,0,0));
        rows.push_back(mk(1,0,0,0,0,3,0,1, 0,0,0,0, 0,0,0, 1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,32,1, 0,0,0,0, 0,0,0, 1,0,0));
        rows.push_back(mk(1,0,0,0,32,4,0,0, 0,0,0,0, 0,0,0, 0,1,0));
        rows.push_back(mk(1,0,0,0,32,3,0,0, 0,0,0,0, 0,0,0, 1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,32,1, 0,0,0,0, 0,0,0, 0,2,0));
        rows.push_back(mk(1,0,0,0,0,0,32,1, 1,32,0,0, 0,0,0, 1,0,0));
        rows.push_back(mk(1,0,32,0,0,1,0,0, 0,0,0,0, 0,0,0, 0,1,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            push_exp($sformatf("x0_f0[%0d]", i), rows[i]);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
            if (rows[i].v && rows[i].hc != 0 && stalls != 16'hFFFF) stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_set_wins();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1,0,0,0,0,0,10,1, 0,0,0,0, 0,0,0, 1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,10,1, 1,10,0,0, 0,0,0, 1,0,0));
        rows.push_back(mk(1,0,0,0,0,0,10,1, 0,0,0,0, 0,0,0, 0,2,0));
        rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 1,0,0, 0,0,0));
        rows.push_back(mk(1,0,0,0,0,0,11,1, 0,0,0,0, 1,0,0, 0,0,0));
        rows.push_back(mk(1,0,0,0,0,0,11,1, 0,0,0,0, 0,0,1, 0,0,0));
        rows.push_back(mk(1,0,11,0,0,1,0,0, 0,0,0,0, 0,0,0, 1,0,0));
        rows.push_back(mk(0,0,10,0,0,1,0,0, 0,0,0,0, 0,0,0, 0,0,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            push_exp($sformatf("set_wins[%0d]", i), rows[i]);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
            if (rows[i].v && rows[i].hc != 0 && stalls != 16'hFFFF) stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1,4,0,0,0,0,40,1, 0,0,0,0, 0,0,0, 1,0,0));
        rows.push_back(mk(1,0,0,40,0,2,41,1, 0,0,0,0, 0,0,0, 0,1,4));
        rows.push_back(mk(1,0,0,40,0,2,41,1, 0,0,0,0, 0,1,0, 0,1,4));
        rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,4));
        rows.push_back(mk(1,0,40,0,0,1,0,0, 0,0,0,0, 0,0,0, 0,1,4));
        foreach (rows[i]) begin
            drive(rows[i]);
            push_exp($sformatf("branch[%0d]", i), rows[i]);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
            if (rows[i].v && rows[i].hc != 0 && stalls != 16'hFFFF) stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate_reset();
        row_t div_row, raw_row, rst_row;
        exp_t e;
        do_reset();
        div_row = mk(1,2,0,0,0,0,20,1, 0,0,0,0, 0,0,0, 1,0,0);
        raw_row = mk(1,0,20,0,0,1,0,0, 0,0,0,0, 0,0,0, 0,1,2);
        rst_row = mk(1,0,20,0,0,1,0,0, 0,0,0,0, 0,0,0, 1,0,0);
        drive(div_row);
        push_exp("sat_issue", div_row);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
        @(posedge clk); #1;
        drive(raw_row);
        repeat (70000) begin
            @(posedge clk);
            if (stalls != 16'hFFFF) stalls++;
        end
        #1;
        push_exp("sat_hold", raw_row);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
        n_cmp++;
        if (stall_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_value: got %h want ffff", stall_cnt); end
        reset = 1'b1;
        stalls = '0;
        #1;
        push_exp("mid_reset", rst_row);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
        @(posedge clk); #1;
        reset = 1'b0;
        push_exp("post_reset", rst_row);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_raw_fdiv();
        test_back_to_back();
        test_x0_f0();
        test_set_wins();
        test_branch();
        test_saturate_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
